// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage_pkg
//  Description : Shared types and constants for the EX/MEM pipeline register.
//                Holds the default datapath width, the packed control bundle
//                carried from EX to MEM, the RUN/WAIT state encoding and a
//                helper that builds a sanitised control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_stage_pkg;

  localparam int unsigned C_XLEN_DEFAULT = 32;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Writes to x0 are dropped here so MEM/WB never see a live write to x0.
  // A simultaneous load+store request is resolved as a load.
  function automatic control_type make_ctrl(input logic       reg_write,
                                            input logic       mem_read,
                                            input logic       mem_write,
                                            input logic [2:0] funct3,
                                            input logic [4:0] rd);
    control_type c;
    c.reg_write = reg_write & (rd != 5'd0);
    c.mem_read  = mem_read;
    c.mem_write = mem_write & ~mem_read;
    c.funct3    = funct3;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX/MEM pipeline register with data-memory handshake.
//                Captures the EX-stage instruction on every non-stalled edge,
//                requests the data memory for loads/stores, stalls upstream
//                until dmem_ack, and flags a sticky timeout if the ack does
//                not arrive within TIMEOUT_CYCLES wait cycles.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                ex_*                   - instruction fields from EX
//                flush                  - turn the incoming EX entry into a bubble
//                dmem_ack / dmem_req    - data memory handshake
//                mem_stall              - hold all upstream stages
//                mem_timeout            - sticky ack-timeout error
//                ex_mem_*               - registered instruction fields to MEM
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned XLEN           = C_XLEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            flush,
  input  logic            dmem_ack,
  output logic            dmem_req,
  output logic            mem_stall,
  output logic            mem_timeout,
  output logic            ex_mem_valid,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_reg_write,
  output logic            ex_mem_mem_read,
  output logic            ex_mem_mem_write,
  output logic [2:0]      ex_mem_funct3,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data
);

  localparam int unsigned          C_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_MAX = C_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [C_CNT_W-1:0]   C_CNT_ONE = C_CNT_W'(1);

  logic                valid_q,   valid_d;
  logic [4:0]          rd_q,      rd_d;
  control_type         ctrl_q,    ctrl_d;
  logic [XLEN-1:0]     alu_q,     alu_d;
  logic [XLEN-1:0]     store_q,   store_d;
  state_e              state_q,   state_d;
  logic [C_CNT_W-1:0]  cnt_q,     cnt_d;
  logic                timeout_q, timeout_d;

  logic                w_advance;
  logic                w_take;

  // Request and stall depend only on the registered entry and the live ack,
  // so a same-cycle ack releases the pipeline with zero latency.
  assign dmem_req  = valid_q & (ctrl_q.mem_read | ctrl_q.mem_write);
  assign mem_stall = dmem_req & ~dmem_ack;
  assign w_advance = ~mem_stall;
  assign w_take    = ex_valid & ~flush;

  // Pipeline register next-state: hold while stalled, otherwise capture EX
  // or a fully zeroed bubble.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    store_d = store_q;
    if (w_advance) begin
      if (w_take) begin
        valid_d = 1'b1;
        rd_d    = ex_rd;
        ctrl_d  = make_ctrl(ex_reg_write, ex_mem_read, ex_mem_write, ex_funct3, ex_rd);
        alu_d   = ex_alu_result;
        store_d = ex_store_data;
      end else begin
        valid_d = 1'b0;
        rd_d    = 5'd0;
        ctrl_d  = '0;
        alu_d   = '0;
        store_d = '0;
      end
    end
  end

  // RUN covers the first request cycle; WAIT is entered only if that cycle
  // saw no ack. The counter tracks WAIT cycles and saturates at the limit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (mem_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + C_CNT_ONE;
          if ((cnt_q + C_CNT_ONE) == C_CNT_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= 5'd0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      store_q   <= '0;
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      store_q   <= store_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout       = timeout_q;
  assign ex_mem_valid      = valid_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_reg_write  = ctrl_q.reg_write;
  assign ex_mem_mem_read   = ctrl_q.mem_read;
  assign ex_mem_mem_write  = ctrl_q.mem_write;
  assign ex_mem_funct3     = ctrl_q.funct3;
  assign ex_mem_alu_result = alu_q;
  assign ex_mem_store_data = store_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage. Directed table of
//                scenarios, hand-written timeout / reset-in-WAIT sequences,
//                and random traffic against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int VW      = 79;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] ex_store_data;
  logic            flush;
  logic            dmem_ack;
  logic            dmem_req;
  logic            mem_stall;
  logic            mem_timeout;
  logic            ex_mem_valid;
  logic [4:0]      ex_mem_rd;
  logic            ex_mem_reg_write;
  logic            ex_mem_mem_read;
  logic            ex_mem_mem_write;
  logic [2:0]      ex_mem_funct3;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .flush(flush), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .mem_stall(mem_stall), .mem_timeout(mem_timeout),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {ex_mem_valid, ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read,
                    ex_mem_mem_write, ex_mem_funct3, ex_mem_alu_result,
                    ex_mem_store_data, dmem_req, mem_stall, mem_timeout};

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural reference model ----------------
  // Pipeline entry as plain fields; the timeout rule is "more than TIMEOUT
  // stalled edges in a row" because the first stalled cycle is the request
  // cycle itself, after which TIMEOUT waiting cycles are allowed.
  logic            m_valid, m_rw, m_mr, m_mw, m_to;
  logic [4:0]      m_rd;
  logic [2:0]      m_f3;
  logic [XLEN-1:0] m_alu, m_st;
  int              m_streak;

  function automatic logic m_req();
    return m_valid && (m_mr || m_mw);
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic stall;
    stall = m_req() && !dmem_ack;
    return {m_valid, m_rd, m_rw, m_mr, m_mw, m_f3, m_alu, m_st, m_req(), stall, m_to};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rd = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_f3 = 0;
    m_alu = 0; m_st = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
      m_to = 0; m_streak = 0;
    end else if (m_req() && !dmem_ack) begin
      m_streak++;
      if (m_streak > TIMEOUT) m_to = 1;
    end else begin
      m_streak = 0;
      if (ex_valid && !flush) begin
        m_valid = 1; m_rd = ex_rd;
        m_rw  = ex_reg_write && (ex_rd != 0);
        m_mr  = ex_mem_read;
        m_mw  = ex_mem_write && !ex_mem_read;
        m_f3  = ex_funct3; m_alu = ex_alu_result; m_st = ex_store_data;
      end else begin
        model_clear();
      end
    end
  endtask

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: combinational check before the edge, registered check after.
  task automatic step();
    #1;
    check("comb", dut_vec, model_vec());
    @(posedge clk);
    model_edge();
    #1;
    check("reg", dut_vec, model_vec());
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] st, input logic fl, input logic ack);
    rst = r; ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_funct3 = f3; ex_alu_result = alu; ex_store_data = st;
    flush = fl; dmem_ack = ack;
  endtask

  typedef struct {
    logic r, v; logic [4:0] rd; logic rw, mr, mw; logic [2:0] f3;
    logic [31:0] alu, st; logic fl, ack;
    logic e_valid; logic [4:0] e_rd; logic e_rw, e_req, e_stall;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // rst, v, rd, rw, mr, mw, f3, alu, st, flush, ack  |  valid, rd, rw, req, stall
    tbl[0]  = '{1,0,0,0,0,0,0,32'h0,32'h0,0,0,            0,0,0,0,0};  // reset bubble
    tbl[1]  = '{0,1,5,1,0,0,0,32'hAA,32'h0,0,0,           1,5,1,0,0};  // ALU rd=5
    tbl[2]  = '{0,1,7,1,0,0,0,32'h11,32'h0,1,0,           0,0,0,0,0};  // flush
    tbl[3]  = '{0,1,0,1,0,0,0,32'h22,32'h0,0,0,           1,0,0,0,0};  // rd=0 drops write
    tbl[4]  = '{0,0,6,1,1,0,0,32'h44,32'h0,0,0,           0,0,0,0,0};  // ex_valid=0
    tbl[5]  = '{0,1,3,1,1,0,2,32'h100,32'h0,0,0,          1,3,1,1,1};  // load, no ack
    tbl[6]  = '{0,1,9,1,0,0,0,32'h33,32'h0,0,0,           1,3,1,1,1};  // held
    tbl[7]  = '{0,1,9,1,0,0,0,32'h33,32'h0,0,0,           1,3,1,1,1};  // held
    tbl[8]  = '{0,1,9,1,0,0,0,32'h33,32'h0,0,0,           1,3,1,1,1};  // held
    tbl[9]  = '{0,1,9,1,0,0,0,32'h33,32'h0,0,1,           1,9,1,0,0};  // ack edge advances
    tbl[10] = '{0,1,0,0,0,1,2,32'h200,32'hDEAD,0,1,       1,0,0,1,0};  // store, ack at once
    tbl[11] = '{0,1,4,1,0,0,0,32'h55,32'h0,0,1,           1,4,1,0,0};  // 1-cycle access
    tbl[12] = '{0,1,8,1,1,0,4,32'h300,32'h0,0,0,          1,8,1,1,1};  // load stalls
    tbl[13] = '{0,1,10,1,0,0,0,32'h66,32'h0,1,0,          1,8,1,1,1};  // flush can't cancel
    tbl[14] = '{0,1,10,1,0,0,0,32'h66,32'h0,1,1,          0,0,0,0,0};  // flush on advance

    drive(1,0,0,0,0,0,0,0,0,0,0);
    m_to = 0; m_streak = 0; model_clear();
    @(posedge clk); model_edge(); #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].mw,
            tbl[i].f3, tbl[i].alu, tbl[i].st, tbl[i].fl, tbl[i].ack);
      step();
      check($sformatf("tbl%0d", i),
            VW'({ex_mem_valid, ex_mem_rd, ex_mem_reg_write, dmem_req, mem_stall}),
            VW'({tbl[i].e_valid, tbl[i].e_rd, tbl[i].e_rw, tbl[i].e_req, tbl[i].e_stall}));
    end
    check("tbl_data", VW'(ex_mem_alu_result), VW'(0));

    // Store that never gets an ack: timeout after TIMEOUT wait cycles, sticky.
    drive(0,1,2,0,0,1,2,32'h400,32'h55,0,0);
    step();
    drive(0,0,0,0,0,0,0,0,0,0,0);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      step();
      if (k == TIMEOUT)     check("to_before", VW'(mem_timeout), VW'(0));
      if (k == TIMEOUT + 1) check("to_set", VW'({mem_timeout, mem_stall, ex_mem_rd}), VW'({2'b11, 5'd2}));
    end
    repeat (3) step();
    check("to_sticky", VW'(mem_timeout), VW'(1));
    drive(1,0,0,0,0,0,0,0,0,0,0);
    step();
    check("to_rst", dut_vec, VW'(0));

    // Reset during the second WAIT cycle of a load abandons the access.
    drive(0,1,3,1,1,0,0,32'h500,32'h0,0,0);
    step();
    drive(0,0,0,0,0,0,0,0,0,0,0);
    step();
    step();
    drive(1,0,0,0,0,0,0,0,0,0,0);
    step();
    check("rst_wait", VW'({dmem_req, mem_stall, ex_mem_valid}), VW'(0));
    drive(0,1,11,1,1,0,0,32'h600,32'h0,0,0);
    step();
    drive(0,1,12,1,0,0,0,32'h77,32'h0,0,1);
    step();
    check("after_rst", VW'({ex_mem_rd, dmem_req, mem_stall}), VW'({5'd12, 2'b00}));

    // Random traffic with an ack drought to reach the timeout path.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0) || (i == 260),
            ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            3'($urandom_range(0, 7)),
            $urandom(), $urandom(),
            ($urandom_range(0, 7) == 0),
            (i >= 200 && i < 240) ? 1'b0 : ($urandom_range(0, 2) != 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL use parameter XLEN, default 32, datapath width.
REQ-002 SHALL use parameter TIMEOUT_CYCLES, default 16, maximum dmem_ack wait before error.
REQ-003 SHALL have one clock and a synchronous, active-high reset, listed first:
  clk  in  1  clock; all state changes on rising edge
  rst  in  1  synchronous active-high reset
REQ-004 SHALL have these ports:
  ex_valid  in  1  EX stage holds a real instruction
  ex_rd  in  5  destination register
  ex_reg_write  in  1  writes register file
  ex_mem_read  in  1  load
  ex_mem_write  in  1  store
  ex_funct3  in  3  access size/sign
  ex_alu_result  in  XLEN  address or ALU value
  ex_store_data  in  XLEN  store data
  flush  in  1  turn incoming EX entry into bubble
  dmem_ack  in  1  data memory completes access this cycle
  dmem_req  out  1  data memory access request
  mem_stall  out  1  hold all upstream stages
  mem_timeout  out  1  sticky error: ack not received in time
  ex_mem_valid  out  1  registered valid
  ex_mem_rd  out  5  registered destination register
  ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write  out  1 each  registered controls
  ex_mem_funct3  out  3  registered funct3
  ex_mem_alu_result, ex_mem_store_data  out  XLEN  registered data

Function
REQ-005 SHALL implement FSM states RUN and WAIT; reset state RUN.
REQ-006 SHALL assert dmem_req combinationally when ex_mem_valid and (ex_mem_mem_read or ex_mem_mem_write), in both states.
REQ-007 SHALL define mem_stall = dmem_req and not dmem_ack (combinational, zero latency).
REQ-008 SHALL advance (capture EX inputs) on every edge where mem_stall = 0; SHALL hold all registered outputs unchanged while mem_stall = 1.
REQ-009 On advance, SHALL capture a bubble (valid, rd, all controls = 0; data fields don't-care, driven 0) if ex_valid = 0 or flush = 1.
REQ-010 SHALL force ex_mem_reg_write = 0 when captured ex_rd = 0.
REQ-011 RUN -> WAIT when mem_stall = 1; WAIT -> RUN on the edge where dmem_ack = 1; ack in the first request cycle means no WAIT entry (1-cycle access).
REQ-012 SHALL count WAIT cycles in a counter cleared on RUN entry, saturating at TIMEOUT_CYCLES; on reaching it SHALL set mem_timeout (sticky until reset) and stay in WAIT.
REQ-013 flush is sampled only on advance edges; upstream holds flush while mem_stall = 1; a held memory op is never cancelled by flush.
REQ-014 Load and store both SHALL stall identically; simultaneous ex_mem_mem_read and ex_mem_mem_write is illegal and treated as read.
REQ-015 dmem_ack with dmem_req = 0 SHALL be ignored.

Reset
REQ-016 Reset SHALL put the register in the bubble state: all ex_mem_* outputs 0, FSM RUN, counter 0, mem_timeout 0.
REQ-017 Reset mid-WAIT SHALL abandon the access: dmem_req deasserts in the first cycle after the reset edge.

Structure
REQ-018 XLEN default, control_type struct (reg_write, mem_read, mem_write, funct3) and FSM state enum SHALL live in the shared common package.
REQ-019 SHALL be a single module; no sub-module.

Verification
REQ-020 Scenario: ALU op rd=5, result 0x0000_00AA, ex_valid=1 -> next cycle ex_mem_rd=5, ex_mem_reg_write=1, dmem_req=0, mem_stall=0.
REQ-021 Scenario: load rd=3, addr 0x100, dmem_ack low 3 cycles then high -> mem_stall=1 for 3 cycles, outputs held, next EX entry captured on the ack edge.
REQ-022 Scenario: flush=1 with valid ALU op rd=7 -> next cycle ex_mem_valid=0, ex_mem_rd=0, ex_mem_reg_write=0.
REQ-023 Scenario: ALU op rd=0, reg_write=1 -> ex_mem_reg_write=0, ex_mem_rd=0.
REQ-024 Scenario: store, dmem_ack never asserted -> mem_timeout=1 after 16 WAIT cycles, stays 1; rst pulse clears it and all outputs return to 0.
REQ-025 Scenario: rst asserted in 2nd WAIT cycle of a load -> following cycle dmem_req=0, mem_stall=0, FSM RUN.
